// File: rtl/call_return_pkg.sv
// Shared state encoding and defaults for the call/return sequencer.
// Holds no logic; latency and backpressure are defined by the modules that use it.
package call_return_pkg;

   localparam int STATE_W        = 3;
   localparam int DEFAULT_RD_LAT = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_PUSH   = 3'd1,
      S_POP    = 3'd2,
      S_WAIT   = 3'd3,
      S_RETURN = 3'd4,
      S_FLUSH  = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

endpackage

// File: rtl/call_return_unit_depth_tracker.sv
// Saturating return-stack occupancy counter with full/empty decode.
// Count updates one edge after inc/dec/clr; clr wins; never wraps, no backpressure.
module depth_tracker #(
   parameter int MEM_SIZE = 64
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        inc,
   input  logic                        dec,
   input  logic                        clr,
   output logic [$clog2(MEM_SIZE)-1:0] count,
   output logic                        is_full,
   output logic                        is_empty
);

   localparam int W = $clog2(MEM_SIZE);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !is_full) begin
         count_d = count_q + W'(1);
      end else if (dec && !is_empty) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign is_full  = (count_q == W'(MEM_SIZE - 1));
   assign is_empty = (count_q == '0);

endmodule

// File: rtl/call_return_unit.sv
// Call/return sequencer driving the return-address stack and fetch redirects.
// Call: push+redirect 1 cycle after request; ret: redirect RD_LAT+1 cycles after; oStall holds off upstream.
module call_return_unit
   import call_return_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int MEM_SIZE   = 64,
   parameter int RD_LAT     = DEFAULT_RD_LAT
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        iCall,
   input  logic                        iRet,
   input  logic                        iFlush,
   input  logic [ADDR_WIDTH-1:0]       iReturnAddr,
   input  logic [ADDR_WIDTH-1:0]       iTarget,
   input  logic [DATA_WIDTH-1:0]       iStackData,
   output logic                        oStackWrite,
   output logic                        oStackRead,
   output logic                        oStackSetSP,
   output logic [$clog2(MEM_SIZE)-1:0] oStackPointerOut,
   output logic [DATA_WIDTH-1:0]       oStackDataOut,
   output logic                        oBranchTaken,
   output logic [ADDR_WIDTH-1:0]       oBranchAddr,
   output logic                        oStall,
   output logic [$clog2(MEM_SIZE)-1:0] oDepth,
   output logic                        oOverflow,
   output logic                        oUnderflow
);

   localparam int CNT_W     = $clog2(RD_LAT + 1);
   localparam int WAIT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ret_q, ret_d;
   logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0]      wait_q, wait_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  is_full, is_empty;
   logic                  unused_data;

   // Only the low ADDR_WIDTH bits of a popped word carry an address.
   assign unused_data = ^iStackData;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      tgt_d   = tgt_q;
      wait_d  = wait_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (state_q == S_FLUSH) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (iFlush) begin
         state_d = S_FLUSH;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (iCall) begin
                  if (is_full) begin
                     state_d = S_FAULT;
                     ovf_d   = 1'b1;
                  end else begin
                     ret_d   = iReturnAddr;
                     tgt_d   = iTarget;
                     state_d = S_PUSH;
                  end
               end else if (iRet) begin
                  if (is_empty) begin
                     state_d = S_FAULT;
                     udf_d   = 1'b1;
                  end else begin
                     state_d = S_POP;
                  end
               end
            end
            S_POP: begin
               if (RD_LAT > 1) begin
                  wait_d  = CNT_W'(WAIT_LOAD);
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RETURN;
               end
            end
            S_WAIT: begin
               if (wait_q == '0) begin
                  state_d = S_RETURN;
               end else begin
                  wait_d = wait_q - CNT_W'(1);
               end
            end
            S_FAULT:                   state_d = S_FAULT;
            S_PUSH, S_RETURN, S_FLUSH: state_d = S_IDLE;
            default:                   state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         ret_q   <= '0;
         tgt_q   <= '0;
         wait_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         tgt_q   <= tgt_d;
         wait_q  <= wait_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   depth_tracker #(
      .MEM_SIZE (MEM_SIZE)
   ) u_depth (
      .Clock    (Clock),
      .Reset    (Reset),
      .inc      (state_q == S_PUSH),
      .dec      (state_q == S_RETURN),
      .clr      (state_q == S_FLUSH),
      .count    (oDepth),
      .is_full  (is_full),
      .is_empty (is_empty)
   );

   // Every output decodes from registered state so reset forces them all to zero at once.
   assign oStackWrite      = (state_q == S_PUSH);
   assign oStackRead       = (state_q == S_POP);
   assign oStackSetSP      = (state_q == S_FLUSH);
   assign oStackPointerOut = '0;
   assign oStackDataOut    = (state_q == S_PUSH) ? DATA_WIDTH'(ret_q) : '0;
   assign oBranchTaken     = (state_q == S_PUSH) || (state_q == S_RETURN);
   assign oBranchAddr      = (state_q == S_PUSH)   ? tgt_q :
                             (state_q == S_RETURN) ? iStackData[ADDR_WIDTH-1:0] : '0;
   assign oStall           = (state_q != S_IDLE);
   assign oOverflow        = ovf_q;
   assign oUnderflow       = udf_q;

endmodule
